// File: rtl/msrv32_pkg.sv
// msrv32_pkg
//   Shared definitions for the msrv32 fetch stage:
//     NOP_INSTR     - canonical RV32I NOP (addi x0, x0, 0)
//     fetch_state_e - fetch FSM states (RUN, MISAL)
//     fq_entry_t    - instruction queue entry {instr, pc, mis}
package msrv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FQ_RUN   = 1'b0,
        FQ_MISAL = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } fq_entry_t;

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// msrv32_fetch_fifo
//   Generic synchronous FIFO with flush, used for the instruction queue and
//   for the pending-fetch PC tracker.
//   Ports:
//     clk_in         - clock, rising edge
//     rst_n_in       - asynchronous active-low reset
//     flush_in       - drop all stored entries (a same-cycle push still lands)
//     push_in        - write push_data_in (ignored when full and not popping)
//     push_data_in   - write data
//     pop_in         - remove the head entry (ignored when empty or flushing)
//     head_data_out  - current head entry (stale when count_out is 0)
//     count_out      - number of stored entries
module msrv32_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flush_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] head_data_out,
    output logic [CNT_W-1:0] count_out
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        do_pop  = pop_in & (count_q != '0) & ~flush_in;
        do_push = push_in & (flush_in | do_pop | (count_q != CNT_MAX));

        // Flush just moves the read pointer onto the write pointer, so a
        // push in the same cycle becomes the only entry.
        if (flush_in) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
        end

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_in;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
            count_d         = count_d + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data_out = mem_q[rd_ptr_q];
    assign count_out     = count_q;

endmodule

// File: rtl/msrv32_fetch_queue.sv
// msrv32_fetch_queue
//   Instruction fetch stage: issues word fetches over a request/grant bus,
//   buffers in-order responses with their PCs, and hands them to the decoder
//   over valid/ready. A redirect flushes the queue and discards responses
//   still in flight.
//   Build option: MSRV32_FETCH_MISALIGN_CHK_EN - when defined, a redirect to
//   a non-word-aligned target stops fetching and presents a single marker
//   entry {NOP, target, mis=1} until the next redirect.
//   Ports:
//     clk_in, rst_n_in        - clock, asynchronous active-low reset
//     redirect_in/_pc_in      - flush and restart fetch at the given target
//     imem_req_out/addr_out   - fetch request and word address
//     imem_gnt_in             - request accepted when req & gnt
//     imem_rvalid_in/rdata_in - in-order response
//     instr_valid_out         - queue head valid
//     instr_out, pc_out       - head instruction / PC (NOP / 0 when empty)
//     instr_ready_in          - decoder consumes head on valid & ready
//     fetch_misaligned_out    - head entry is a misaligned-target marker
module msrv32_fetch_queue
    import msrv32_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter logic [31:0] BOOT_ADDR   = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    input  logic        instr_ready_in,
    output logic        fetch_misaligned_out
);

    localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned ENTRY_W    = $bits(fq_entry_t);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W:0] OCC_LIM = (CNT_W + 1)'(QUEUE_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             issue_en;
    logic             grant;
    logic             redirect_mis;
    logic [31:0]      redirect_pc_aligned;
    logic [CNT_W:0]   occupancy;

    logic             q_push, q_pop;
    fq_entry_t        q_wdata, q_head;
    logic [CNT_W-1:0] q_count;

    logic             p_push, p_pop;
    logic [31:0]      p_head;
    logic [CNT_W-1:0] p_count;

    assign redirect_pc_aligned = redirect_pc_in & ~32'h0000_0003;

`ifdef MSRV32_FETCH_MISALIGN_CHK_EN
    assign redirect_mis = redirect_in & (redirect_pc_in[1:0] != 2'b00);
`else
    assign redirect_mis = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= FQ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef MSRV32_FETCH_MISALIGN_CHK_EN
        if (redirect_in) begin
            state_d = redirect_mis ? FQ_MISAL : FQ_RUN;
        end
`else
        state_d = FQ_RUN;
`endif
    end

    always_comb begin
        issue_en = (state_q == FQ_RUN);
    end

    // ---------------- Issue ----------------
    // Queued plus outstanding is capped at QUEUE_DEPTH, so every response
    // that is kept always finds room in the queue. Discarded responses still
    // count as outstanding until they return.
    assign occupancy     = {1'b0, q_count} + {1'b0, outstanding_q};
    assign imem_req_out  = rst_n_in & issue_en & ~redirect_in & (occupancy < OCC_LIM);
    assign imem_addr_out = fetch_pc_q;
    assign grant         = imem_req_out & imem_gnt_in;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (imem_rvalid_in) begin
            outstanding_d = outstanding_q - ONE;
        end

        if (redirect_in) begin
            // Everything still in flight after this cycle's response is stale.
            discard_d  = outstanding_d;
            fetch_pc_d = redirect_pc_aligned;
        end else begin
            if (grant) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                outstanding_d = outstanding_d + ONE;
            end
            if (imem_rvalid_in && (discard_q != '0)) begin
                discard_d = discard_q - ONE;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fetch_pc_q    <= BOOT_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // ---------------- Pending-PC tracker ----------------
    // Holds PCs of live (non-discarded) requests; flushed on redirect, so
    // discarded responses never pop it.
    assign p_push = grant;
    assign p_pop  = imem_rvalid_in & ~redirect_in & (discard_q == '0);

    msrv32_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (QUEUE_DEPTH)
    ) u_pending_fifo (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .flush_in      (redirect_in),
        .push_in       (p_push),
        .push_data_in  (fetch_pc_q),
        .pop_in        (p_pop),
        .head_data_out (p_head),
        .count_out     (p_count)
    );

    // ---------------- Instruction queue ----------------
    assign q_push = (p_pop & (p_count != '0)) | redirect_mis;
    assign q_pop  = instr_valid_out & instr_ready_in & ~redirect_in;

    always_comb begin
        if (redirect_mis) begin
            q_wdata = '{instr: NOP_INSTR, pc: redirect_pc_in, mis: 1'b1};
        end else begin
            q_wdata = '{instr: imem_rdata_in, pc: p_head, mis: 1'b0};
        end
    end

    msrv32_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_instr_fifo (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .flush_in      (redirect_in),
        .push_in       (q_push),
        .push_data_in  (q_wdata),
        .pop_in        (q_pop),
        .head_data_out (q_head),
        .count_out     (q_count)
    );

    // ---------------- Decoder outputs ----------------
    assign instr_valid_out = (q_count != '0);
    assign instr_out       = instr_valid_out ? q_head.instr : NOP_INSTR;
    assign pc_out          = instr_valid_out ? q_head.pc : 32'h0000_0000;

`ifdef MSRV32_FETCH_MISALIGN_CHK_EN
    assign fetch_misaligned_out = instr_valid_out & q_head.mis;
`else
    assign fetch_misaligned_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_fetch_queue.sv
// tb_msrv32_fetch_queue
//   Directed bench for msrv32_fetch_queue with a queue-based reference model
//   and an in-order instruction memory responder (one-cycle minimum latency).
//   Build option: MSRV32_FETCH_MISALIGN_CHK_EN selects the misaligned-marker
//   checks.
module tb_msrv32_fetch_queue;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0040;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_ready_in;
    logic        fetch_misaligned_out;

    always #5 clk_in = ~clk_in;

    msrv32_fetch_queue #(
        .QUEUE_DEPTH (DEPTH),
        .BOOT_ADDR   (BOOT)
    ) dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .redirect_in          (redirect_in),
        .redirect_pc_in       (redirect_pc_in),
        .imem_req_out         (imem_req_out),
        .imem_addr_out        (imem_addr_out),
        .imem_gnt_in          (imem_gnt_in),
        .imem_rvalid_in       (imem_rvalid_in),
        .imem_rdata_in        (imem_rdata_in),
        .instr_valid_out      (instr_valid_out),
        .instr_out            (instr_out),
        .pc_out               (pc_out),
        .instr_ready_in       (instr_ready_in),
        .fetch_misaligned_out (fetch_misaligned_out)
    );

    // Stimulus knobs
    bit          in_rst, redir, ready, gnt, rv_en;
    logic [31:0] redir_pc;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Values seen at the last compare point, for hand-computed pins
    logic        obs_req, obs_valid, obs_mis;
    logic [31:0] obs_addr, obs_instr, obs_pc;

    // Reference model: decoder-visible queue, in-flight fetches, fetch PC
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;
    typedef struct {
        logic [31:0] pc;
        bit          drop;
    } pend_t;

    ent_t        mq[$];
    pend_t       mp[$];
    logic [31:0] memq[$];
    logic [31:0] m_pc;
    bit          m_misal;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0000} ^ a ^ 32'h5A00_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit          rv;
        logic        e_req, e_valid, e_mis;
        logic [31:0] e_instr, e_pc;
        pend_t       p;

        @(negedge clk_in);
        rst_n_in = ~in_rst;
        if (in_rst) begin
            mq.delete();
            mp.delete();
            memq.delete();
            m_pc    = BOOT;
            m_misal = 1'b0;
        end
        redirect_in    = redir;
        redirect_pc_in = redir_pc;
        instr_ready_in = ready;
        imem_gnt_in    = gnt;
        rv             = !in_rst && rv_en && (memq.size() > 0);
        imem_rvalid_in = rv;
        imem_rdata_in  = rv ? mem_word(memq[0]) : $urandom();
        #1;

        e_req   = !in_rst && !redir && !m_misal && (mq.size() + mp.size() < DEPTH);
        e_valid = (mq.size() != 0);
        e_instr = e_valid ? mq[0].instr : NOP;
        e_pc    = e_valid ? mq[0].pc : 32'h0;
        e_mis   = e_valid ? mq[0].mis : 1'b0;

        chk("req",   {31'b0, imem_req_out},         {31'b0, e_req});
        chk("addr",  imem_addr_out,                 m_pc);
        chk("valid", {31'b0, instr_valid_out},      {31'b0, e_valid});
        chk("instr", instr_out,                     e_instr);
        chk("pc",    pc_out,                        e_pc);
        chk("mis",   {31'b0, fetch_misaligned_out}, {31'b0, e_mis});

        obs_req   = imem_req_out;
        obs_addr  = imem_addr_out;
        obs_valid = instr_valid_out;
        obs_instr = instr_out;
        obs_pc    = pc_out;
        obs_mis   = fetch_misaligned_out;

        @(posedge clk_in);
        cyc++;
        if (!in_rst) begin
            if (redir) begin
                mq.delete();
                if (rv && mp.size() > 0) void'(mp.pop_front());
                foreach (mp[i]) mp[i].drop = 1'b1;
                m_pc = redir_pc & ~32'h3;
`ifdef MSRV32_FETCH_MISALIGN_CHK_EN
                if (redir_pc[1:0] != 2'b00) begin
                    m_misal = 1'b1;
                    mq.push_back('{pc: redir_pc, instr: NOP, mis: 1'b1});
                end else begin
                    m_misal = 1'b0;
                end
`endif
            end else begin
                if (e_valid && ready) void'(mq.pop_front());
                if (rv && mp.size() > 0) begin
                    p = mp.pop_front();
                    if (!p.drop) mq.push_back('{pc: p.pc, instr: mem_word(p.pc), mis: 1'b0});
                end
                if (e_req && gnt) begin
                    mp.push_back('{pc: m_pc, drop: 1'b0});
                    memq.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (rv) void'(memq.pop_front());
        end
    endtask

    // Steps until the head is valid, bounded; a timeout shows as a pc miss.
    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int k = 0;
        do begin
            step();
            k++;
        end while (!obs_valid && k < 16);
        chk({name, "_valid"}, {31'b0, obs_valid}, 32'd1);
        chk({name, "_pc"}, obs_pc, exp_pc);
        chk({name, "_instr"}, obs_instr, mem_word(exp_pc));
    endtask

    initial begin
        rst_n_in       = 1'b0;
        redirect_in    = 1'b0;
        redirect_pc_in = '0;
        imem_gnt_in    = 1'b0;
        imem_rvalid_in = 1'b0;
        imem_rdata_in  = '0;
        instr_ready_in = 1'b0;
        in_rst = 1'b1; redir = 1'b0; redir_pc = '0;
        ready = 1'b1; gnt = 1'b1; rv_en = 1'b1;
        m_pc = BOOT; m_misal = 1'b0;

        // Reset values
        step();
        chk("pin_rst_req",   {31'b0, obs_req},   32'd0);
        chk("pin_rst_addr",  obs_addr,           BOOT);
        chk("pin_rst_valid", {31'b0, obs_valid}, 32'd0);
        chk("pin_rst_instr", obs_instr,          NOP);
        chk("pin_rst_pc",    obs_pc,             32'd0);
        step();

        // Streaming: gnt=1, response one cycle after grant, ready=1
        in_rst = 1'b0;
        step();
        chk("pin_first_req",  {31'b0, obs_req}, 32'd1);
        chk("pin_first_addr", obs_addr,         BOOT);
        step();
        chk("pin_second_addr", obs_addr, BOOT + 32'd4);
        step();
        chk("pin_head0_pc",    obs_pc,            BOOT);
        chk("pin_head0_instr", obs_instr,         mem_word(BOOT));
        chk("pin_full_noreq",  {31'b0, obs_req},  32'd0);
        step();
        chk("pin_head1_pc", obs_pc,   BOOT + 32'd4);
        chk("pin_third_addr", obs_addr, BOOT + 32'd8);
        repeat (10) step();

        // Decoder stall: issue stops once queue + outstanding reach depth
        ready = 1'b0;
        repeat (6) step();
        chk("pin_stall_req",   {31'b0, obs_req},   32'd0);
        chk("pin_stall_valid", {31'b0, obs_valid}, 32'd1);
        ready = 1'b1;
        repeat (8) step();

        // Grant withheld on alternate cycles: address must hold
        for (int i = 0; i < 10; i++) begin
            gnt = (i % 2 == 1);
            step();
        end
        gnt = 1'b1;

        // Redirect with two fetches in flight, one response arriving
        rv_en = 1'b0;
        repeat (4) step();
        redir = 1'b1; redir_pc = 32'h0000_0100; rv_en = 1'b1;
        step();
        redir = 1'b0;
        step();
        chk("pin_redir_req",  {31'b0, obs_req}, 32'd1);
        chk("pin_redir_addr", obs_addr,         32'h0000_0100);
        wait_valid("pin_redir", 32'h0000_0100);
        repeat (4) step();

        // Redirect with two fetches in flight, none arriving that cycle
        rv_en = 1'b0;
        repeat (4) step();
        redir = 1'b1; redir_pc = 32'h0000_0180;
        step();
        redir = 1'b0; rv_en = 1'b1;
        wait_valid("pin_redir2", 32'h0000_0180);
        repeat (4) step();

        // Redirect, pop and response in the same cycle
        ready = 1'b0;
        repeat (4) step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        redir = 1'b1; redir_pc = 32'h0000_0300; ready = 1'b1;
        step();
        redir = 1'b0;
        step();
        chk("pin_rpr_valid", {31'b0, obs_valid}, 32'd0);
        chk("pin_rpr_addr",  obs_addr,           32'h0000_0300);
        wait_valid("pin_rpr", 32'h0000_0300);
        repeat (4) step();

`ifdef MSRV32_FETCH_MISALIGN_CHK_EN
        // Misaligned redirect target produces a single marker entry
        redir = 1'b1; redir_pc = 32'h0000_0102;
        step();
        redir = 1'b0; ready = 1'b0;
        step();
        chk("pin_mis_valid", {31'b0, obs_valid}, 32'd1);
        chk("pin_mis_flag",  {31'b0, obs_mis},   32'd1);
        chk("pin_mis_pc",    obs_pc,             32'h0000_0102);
        chk("pin_mis_instr", obs_instr,          NOP);
        chk("pin_mis_req",   {31'b0, obs_req},   32'd0);
        repeat (3) step();
        ready = 1'b1;
        repeat (3) step();
        chk("pin_mis_drained", {31'b0, obs_valid}, 32'd0);
        chk("pin_mis_noreq",   {31'b0, obs_req},   32'd0);
        redir = 1'b1; redir_pc = 32'h0000_0200;
        step();
        redir = 1'b0;
        step();
        chk("pin_mis_exit_req",  {31'b0, obs_req}, 32'd1);
        chk("pin_mis_exit_addr", obs_addr,         32'h0000_0200);
        repeat (6) step();
`else
        // Without the check, target low bits are simply cleared
        redir = 1'b1; redir_pc = 32'h0000_0102;
        step();
        redir = 1'b0;
        step();
        chk("pin_align_req",  {31'b0, obs_req}, 32'd1);
        chk("pin_align_addr", obs_addr,         32'h0000_0100);
        chk("pin_align_mis",  {31'b0, obs_mis}, 32'd0);
        repeat (6) step();
`endif

        // Reset pulsed mid-stream
        ready = 1'b1; rv_en = 1'b1; gnt = 1'b1;
        repeat (3) step();
        in_rst = 1'b1;
        step();
        chk("pin_mid_rst_req",   {31'b0, obs_req},   32'd0);
        chk("pin_mid_rst_valid", {31'b0, obs_valid}, 32'd0);
        chk("pin_mid_rst_instr", obs_instr,          NOP);
        chk("pin_mid_rst_pc",    obs_pc,             32'd0);
        chk("pin_mid_rst_addr",  obs_addr,           BOOT);
        in_rst = 1'b0;
        step();
        chk("pin_post_rst_req",  {31'b0, obs_req}, 32'd1);
        chk("pin_post_rst_addr", obs_addr,         BOOT);
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
